npu_inst_dispatcher: RTL and testbench
======================================

# npu_inst_dispatcher

FPGA-side consumer of the HPS→NPU instruction mailbox in `Computer_System`. It polls the `inst_valid` flag memory slot by slot, fetches the 128-bit instruction from `inst_sram`, and hands it to the NPU core over a valid/ready handshake. When the core finishes, it posts a completion byte to `done_sram` and clears the slot's valid flag, which returns the slot to the HPS. It drives the three on-chip memory s1 ports from the fabric side.

## Interface
- `NUM_SLOTS`, 256, number of mailbox slots; power of two, 2..256; slot index = ptr[log2(NUM_SLOTS)-1:0].
- `RD_LAT`, 1, s1 read latency in cycles (1 or 2); applies to all three memories.
- `clk` input 1: system clock, same clock as the s1 ports.
- `reset_n` input 1: asynchronous active-low reset.
- `enable` input 1: run/stop control from HPS glue logic.
- `inst_valid_s1_address` output 9: equals {1'b0, ptr}.
- `inst_valid_s1_clken` / `_chipselect` / `_write` output 1 each.
- `inst_valid_s1_writedata` output 8: always 8'h00 (flag clear).
- `inst_valid_s1_readdata` input 8: bit0 = slot valid; bits 7:1 are ignored.
- `inst_sram_s1_address` output 8: ptr.
- `inst_sram_s1_clken` / `_chipselect` output 1 each.
- `inst_sram_s1_write` output 1: tied 0.
- `inst_sram_s1_writedata` output 128: tied 0.
- `inst_sram_s1_byteenable` output 16: tied 16'hFFFF.
- `inst_sram_s1_readdata` input 128: instruction word.
- `done_sram_s1_address` output 9: {1'b0, ptr}.
- `done_sram_s1_clken` / `_chipselect` / `_write` output 1 each.
- `done_sram_s1_writedata` output 8: {core_status, 1'b1}.
- `done_sram_s1_readdata` input 8: unused.
- `core_inst` output 128: latched instruction, stable while `core_inst_valid`=1.
- `core_inst_valid` output 1 / `core_inst_ready` input 1: issue handshake.
- `core_done` input 1: single-cycle completion pulse.
- `core_status` input 7: sampled on the `core_done` cycle.
- `busy` output 1: high in every state except IDLE.
- `slot_ptr` output 8: current slot index.
- `inst_count` output 32: count of completed instructions; wraps.

## Operation
- States: IDLE, POLL, PWAIT, FETCH, FWAIT, ISSUE, EXEC, WR_DONE, CLR_VALID, ADVANCE.
- **IDLE → POLL**: when `enable`=1.
- **POLL**: one cycle; `inst_valid` cs=clken=1, write=0.
- **PWAIT**: RD_LAT cycles; readdata is sampled on the last one.
  - bit0=1 → FETCH.
  - bit0=0 → POLL (same slot) if `enable`, else IDLE.
- **FETCH** (1 cycle) and **FWAIT** (RD_LAT cycles): `inst_sram` read; readdata latched into `core_inst` on the last FWAIT cycle.
- **ISSUE**: `core_inst_valid`=1 until the cycle where `core_inst_ready`=1, then EXEC. `core_inst` must not change during ISSUE.
- **EXEC**: wait for `core_done`. A `core_done` in the same cycle as the ISSUE handshake is ignored; only EXEC-state pulses count. `core_status` is latched.
- **WR_DONE**: one-cycle `done_sram` write of {status,1'b1} to slot ptr.
- **CLR_VALID**: one-cycle `inst_valid` write of 8'h00 to slot ptr. The done byte is always written before the flag is cleared.
- **ADVANCE**: ptr ← (ptr+1) mod NUM_SLOTS; `inst_count`++. Then POLL if `enable`, else IDLE.
- **`enable` deasserted** after leaving PWAIT: the current instruction runs to ADVANCE; no abort.
- **Strobes**: chipselect/clken are high only in each memory's access and wait cycles; all other strobes are 0.
- **Reset**, asynchronous, including mid-instruction: state IDLE, ptr 0, `inst_count` 0, `core_inst` 0, every strobe/valid/busy 0. An in-flight core instruction is abandoned; the slot is neither written to `done_sram` nor cleared.

## Timing
- **Poll period**: 1+RD_LAT cycles per empty check of a slot.
- **Latency**, with POLL entered at t and RD_LAT=1:
  - PWAIT t+1, FETCH t+2, FWAIT t+3.
  - `core_inst_valid` rises at t+4.
  - In general, `core_inst_valid` rises 2+2·RD_LAT cycles after POLL entry.
- **Retirement**: `core_done` at cycle d → WR_DONE at d+1, CLR_VALID at d+2, ADVANCE at d+3, next POLL at d+4.
- **Ordering**: strictly in slot order; no skipping; wraps from NUM_SLOTS-1 to 0.

## Test plan
- **Single instruction**: slot0 valid=8'h01, inst=128'hA5..5A, `core_inst_ready` high, `core_done` 5 cycles after the handshake with status 7'h03 → `core_inst`=A5..5A at t+4, done_sram[0]=8'h07, inst_valid[0]=8'h00, ptr=1, `inst_count`=1.
- **Back-pressure**: ready held low 10 cycles → `core_inst_valid` stays high and `core_inst` stable throughout; exactly one handshake occurs.
- **Wrap**: NUM_SLOTS=4, slots 0–3 filled and then slot 0 refilled → 5 completions; ptr sequence 0,1,2,3,0; `inst_count`=5.
- **Empty polling**: slot 2 invalid for 20 cycles, then set → no `inst_sram` access and no writes until set; the fetch follows the next PWAIT.
- **RD_LAT=2**: repeat the single-instruction case → `core_inst_valid` at t+6 with correct data.
- **Reset and enable**: `reset_n` low during EXEC → all outputs 0, ptr 0, slot flag untouched. `enable` dropped during EXEC → slot completes, then IDLE with `busy`=0.

Source files
------------

// File: rtl/npu_inst_dispatcher.sv
// Drains the HPS->NPU mailbox in slot order: poll flag, fetch 128-bit word, issue to core, post done byte, clear flag.
// Issue 2+2*RD_LAT cycles after POLL; core_inst_ready low parks the word in ISSUE, and the core sets EXEC length via core_done.
module npu_inst_dispatcher #(
  parameter int NUM_SLOTS = 256,
  parameter int RD_LAT    = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  output logic [8:0]   inst_valid_s1_address,
  output logic         inst_valid_s1_clken,
  output logic         inst_valid_s1_chipselect,
  output logic         inst_valid_s1_write,
  output logic [7:0]   inst_valid_s1_writedata,
  input  logic [7:0]   inst_valid_s1_readdata,
  output logic [7:0]   inst_sram_s1_address,
  output logic         inst_sram_s1_clken,
  output logic         inst_sram_s1_chipselect,
  output logic         inst_sram_s1_write,
  output logic [127:0] inst_sram_s1_writedata,
  output logic [15:0]  inst_sram_s1_byteenable,
  input  logic [127:0] inst_sram_s1_readdata,
  output logic [8:0]   done_sram_s1_address,
  output logic         done_sram_s1_clken,
  output logic         done_sram_s1_chipselect,
  output logic         done_sram_s1_write,
  output logic [7:0]   done_sram_s1_writedata,
  input  logic [7:0]   done_sram_s1_readdata,
  output logic [127:0] core_inst,
  output logic         core_inst_valid,
  input  logic         core_inst_ready,
  input  logic         core_done,
  input  logic [6:0]   core_status,
  output logic         busy,
  output logic [7:0]   slot_ptr,
  output logic [31:0]  inst_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_PWAIT, S_FETCH, S_FWAIT,
    S_ISSUE, S_EXEC, S_WR_DONE, S_CLR_VALID, S_ADVANCE
  } state_t;

  localparam logic [7:0] PTR_MASK = 8'(NUM_SLOTS - 1);
  localparam logic       LAT_LAST = 1'(RD_LAT - 1);

  state_t     state, state_nxt;
  logic [7:0] ptr;
  logic       lat_cnt;
  logic       lat_last;
  logic [6:0] status_q;
  logic       unused_ok;

  assign lat_last  = (lat_cnt == LAT_LAST);
  assign unused_ok = ^{done_sram_s1_readdata, inst_valid_s1_readdata[7:1]};

  assign inst_valid_s1_address   = {1'b0, ptr};
  assign inst_valid_s1_writedata = 8'h00;
  assign inst_sram_s1_address    = ptr;
  assign inst_sram_s1_write      = 1'b0;
  assign inst_sram_s1_writedata  = '0;
  assign inst_sram_s1_byteenable = 16'hFFFF;
  assign done_sram_s1_address    = {1'b0, ptr};
  assign done_sram_s1_writedata  = {status_q, 1'b1};
  assign slot_ptr                = ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (enable) state_nxt = S_POLL;
      S_POLL:      state_nxt = S_PWAIT;
      S_PWAIT: begin
        if (lat_last) begin
          if (inst_valid_s1_readdata[0]) state_nxt = S_FETCH;
          else                           state_nxt = enable ? S_POLL : S_IDLE;
        end
      end
      S_FETCH:     state_nxt = S_FWAIT;
      S_FWAIT:     if (lat_last) state_nxt = S_ISSUE;
      S_ISSUE:     if (core_inst_ready) state_nxt = S_EXEC;
      // a core_done coincident with the issue handshake is seen in ISSUE and dropped
      S_EXEC:      if (core_done) state_nxt = S_WR_DONE;
      S_WR_DONE:   state_nxt = S_CLR_VALID;
      S_CLR_VALID: state_nxt = S_ADVANCE;
      S_ADVANCE:   state_nxt = enable ? S_POLL : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inst_valid_s1_chipselect = 1'b0;
    inst_valid_s1_clken      = 1'b0;
    inst_valid_s1_write      = 1'b0;
    inst_sram_s1_chipselect  = 1'b0;
    inst_sram_s1_clken       = 1'b0;
    done_sram_s1_chipselect  = 1'b0;
    done_sram_s1_clken       = 1'b0;
    done_sram_s1_write       = 1'b0;
    core_inst_valid          = 1'b0;
    busy                     = (state != S_IDLE);
    case (state)
      S_POLL, S_PWAIT: begin
        inst_valid_s1_chipselect = 1'b1;
        inst_valid_s1_clken      = 1'b1;
      end
      S_FETCH, S_FWAIT: begin
        inst_sram_s1_chipselect = 1'b1;
        inst_sram_s1_clken      = 1'b1;
      end
      S_ISSUE: core_inst_valid = 1'b1;
      S_WR_DONE: begin
        done_sram_s1_chipselect = 1'b1;
        done_sram_s1_clken      = 1'b1;
        done_sram_s1_write      = 1'b1;
      end
      S_CLR_VALID: begin
        inst_valid_s1_chipselect = 1'b1;
        inst_valid_s1_clken      = 1'b1;
        inst_valid_s1_write      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      lat_cnt    <= 1'b0;
      inst_count <= '0;
      core_inst  <= '0;
      status_q   <= '0;
    end else begin
      if ((state == S_PWAIT || state == S_FWAIT) && !lat_last) begin
        lat_cnt <= lat_cnt + 1'b1;
      end else begin
        lat_cnt <= 1'b0;
      end
      if (state == S_FWAIT && lat_last) begin
        core_inst <= inst_sram_s1_readdata;
      end
      if (state == S_EXEC && core_done) begin
        status_q <= core_status;
      end
      if (state == S_ADVANCE) begin
        ptr        <= (ptr + 8'd1) & PTR_MASK;
        inst_count <= inst_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_npu_inst_dispatcher.sv
// Two dispatchers (RD_LAT 1 and 2, four slots) against behavioural s1 memories and a scripted core.
module tb_npu_inst_dispatcher;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         enable [2], core_ready [2], core_done [2];
  logic [6:0]   core_status [2];
  logic [8:0]   iv_addr [2], dn_addr [2];
  logic         iv_ck [2], iv_cs [2], iv_we [2], is_ck [2], is_cs [2], is_we [2];
  logic         dn_ck [2], dn_cs [2], dn_we [2];
  logic [7:0]   iv_wd [2], iv_rd [2], is_addr [2], dn_wd [2], dn_rd [2];
  logic [127:0] is_wd [2], is_rd [2], c_inst [2];
  logic [15:0]  is_be [2];
  logic         c_vld [2], busy [2];
  logic [7:0]   sptr [2];
  logic [31:0]  icnt [2];

  logic [7:0]   vmem [2][NS] = '{default: '0};
  logic [7:0]   dmem [2][NS] = '{default: '0};
  logic [127:0] imem [2][NS] = '{default: '0};
  logic [7:0]   iv_r1 [2], iv_r2 [2];
  logic [127:0] is_r1 [2], is_r2 [2];
  logic         hw_vld [2];
  logic [1:0]   hw_slot [2];
  logic [7:0]   hw_val [2];

  // memory models: one read register per cycle of latency, advanced only while clken is high
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (hw_vld[g]) vmem[g][hw_slot[g]] <= hw_val[g];
      if (iv_cs[g] && iv_ck[g]) begin
        if (iv_we[g]) vmem[g][iv_addr[g][1:0]] <= iv_wd[g];
        else          iv_r1[g] <= vmem[g][iv_addr[g][1:0]];
        iv_r2[g] <= iv_r1[g];
      end
      if (is_cs[g] && is_ck[g]) begin
        is_r1[g] <= imem[g][is_addr[g][1:0]];
        is_r2[g] <= is_r1[g];
      end
      if (dn_cs[g] && dn_ck[g] && dn_we[g]) dmem[g][dn_addr[g][1:0]] <= dn_wd[g];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign iv_rd[g] = (g == 0) ? iv_r1[g] : iv_r2[g];
    assign is_rd[g] = (g == 0) ? is_r1[g] : is_r2[g];
    assign dn_rd[g] = 8'h00;
    npu_inst_dispatcher #(.NUM_SLOTS(NS), .RD_LAT(g + 1)) u_dut (
      .clk(clk), .reset_n(reset_n), .enable(enable[g]),
      .inst_valid_s1_address(iv_addr[g]), .inst_valid_s1_clken(iv_ck[g]),
      .inst_valid_s1_chipselect(iv_cs[g]), .inst_valid_s1_write(iv_we[g]),
      .inst_valid_s1_writedata(iv_wd[g]), .inst_valid_s1_readdata(iv_rd[g]),
      .inst_sram_s1_address(is_addr[g]), .inst_sram_s1_clken(is_ck[g]),
      .inst_sram_s1_chipselect(is_cs[g]), .inst_sram_s1_write(is_we[g]),
      .inst_sram_s1_writedata(is_wd[g]), .inst_sram_s1_byteenable(is_be[g]),
      .inst_sram_s1_readdata(is_rd[g]),
      .done_sram_s1_address(dn_addr[g]), .done_sram_s1_clken(dn_ck[g]),
      .done_sram_s1_chipselect(dn_cs[g]), .done_sram_s1_write(dn_we[g]),
      .done_sram_s1_writedata(dn_wd[g]), .done_sram_s1_readdata(dn_rd[g]),
      .core_inst(c_inst[g]), .core_inst_valid(c_vld[g]), .core_inst_ready(core_ready[g]),
      .core_done(core_done[g]), .core_status(core_status[g]),
      .busy(busy[g]), .slot_ptr(sptr[g]), .inst_count(icnt[g])
    );
  end

  typedef struct { int g; logic [127:0] d; } inst_exp_t;
  typedef struct { int g; logic [8:0] addr; logic [7:0] b; } done_exp_t;
  inst_exp_t inst_q [$];
  done_exp_t done_q [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt [2], dly [2], hs_cyc [2], hs_count [2];
  logic [6:0] stat_cfg [2];
  logic       spur_en [2], clr_pending [2];
  logic [8:0] last_done_addr [2];

  // one clock: score what the DUTs show now, cross the edge, then play the core's done pulse
  task automatic step();
    inst_exp_t ie;
    done_exp_t de;
    for (int g = 0; g < 2; g++) begin
      if (c_vld[g] && core_ready[g]) begin
        hs_count[g]++;
        hs_cyc[g] = cyc;
        done_cnt[g] = dly[g];
        if (spur_en[g]) begin
          core_done[g] = 1'b1;
          core_status[g] = 7'h55;
        end
        checks++;
        if (inst_q.size() == 0) begin
          failures++;
          $display("FAIL issue_unexpected dut%0d got=%h", g, c_inst[g]);
        end else begin
          ie = inst_q.pop_front();
          if (ie.g != g || c_inst[g] !== ie.d) begin
            failures++;
            $display("FAIL issue_data dut%0d got=%h exp=%h (exp dut%0d)", g, c_inst[g], ie.d, ie.g);
          end
        end
      end
      if (dn_cs[g] && dn_we[g]) begin
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected dut%0d addr=%0d data=%h", g, dn_addr[g], dn_wd[g]);
        end else begin
          de = done_q.pop_front();
          if (de.g != g || dn_addr[g] !== de.addr || dn_wd[g] !== de.b || cyc != hs_cyc[g] + dly[g] + 1) begin
            failures++;
            $display("FAIL done_write dut%0d got addr=%0d data=%h cyc=%0d exp dut%0d addr=%0d data=%h cyc=%0d",
                     g, dn_addr[g], dn_wd[g], cyc, de.g, de.addr, de.b, hs_cyc[g] + dly[g] + 1);
          end
        end
        last_done_addr[g] = dn_addr[g];
        clr_pending[g] = 1'b1;
      end
      if (iv_cs[g] && iv_we[g]) begin
        checks++;
        if (!clr_pending[g] || iv_addr[g] !== last_done_addr[g] || iv_wd[g] !== 8'h00) begin
          failures++;
          $display("FAIL flag_clear dut%0d got addr=%0d data=%h pending=%0b exp addr=%0d data=00 pending=1",
                   g, iv_addr[g], iv_wd[g], clr_pending[g], last_done_addr[g]);
        end
        clr_pending[g] = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
    for (int g = 0; g < 2; g++) begin
      hw_vld[g] = 1'b0;
      core_done[g] = 1'b0;
      if (done_cnt[g] > 0) begin
        done_cnt[g]--;
        if (done_cnt[g] == 0) begin
          core_done[g] = 1'b1;
          core_status[g] = stat_cfg[g];
        end
      end
    end
  endtask

  task automatic host_set(input int g, input logic [1:0] slot, input logic [7:0] val);
    hw_vld[g] = 1'b1;
    hw_slot[g] = slot;
    hw_val[g] = val;
    step();
  endtask

  task automatic wait_valid(input int g, input int budget, output int n);
    n = 0;
    while (!c_vld[g] && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_count(input int g, input logic [31:0] target, input int budget);
    int n = 0;
    while (icnt[g] !== target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (icnt[g] !== target) begin
      failures++;
      $display("FAIL inst_count_wait dut%0d got=%0d exp=%0d", g, icnt[g], target);
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({busy[g], c_vld[g], sptr[g], icnt[g]} !== 42'd0 || c_inst[g] !== 128'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d busy=%0b vld=%0b ptr=%0d cnt=%0d inst=%h exp all zero",
                 g, busy[g], c_vld[g], sptr[g], icnt[g], c_inst[g]);
      end
      checks++;
      if ({iv_cs[g], iv_ck[g], iv_we[g], is_cs[g], is_ck[g], is_we[g], dn_cs[g], dn_ck[g], dn_we[g]} !== 9'd0) begin
        failures++;
        $display("FAIL reset_strobes dut%0d got=%b exp=000000000", g,
                 {iv_cs[g], iv_ck[g], iv_we[g], is_cs[g], is_ck[g], is_we[g], dn_cs[g], dn_ck[g], dn_we[g]});
      end
    end
    reset_n = 1'b1;
    step();
    step();
    checks++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL idle_without_enable busy=%0b%0b exp=00", busy[0], busy[1]);
    end
  endtask

  task automatic test_single();
    int n;
    logic [127:0] w = {8{16'hA55A}};
    imem[0][0] = w;
    inst_q.push_back('{0, w});
    done_q.push_back('{0, 9'd0, 8'h07});
    dly[0] = 5;
    stat_cfg[0] = 7'h03;
    core_ready[0] = 1'b1;
    host_set(0, 2'd0, 8'h01);
    enable[0] = 1'b1;
    wait_valid(0, 20, n);
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL issue_latency_rd1 got=%0d exp=5", n);
    end
    checks++;
    if (c_inst[0] !== w || is_be[0] !== 16'hFFFF || is_we[0] !== 1'b0 || is_wd[0] !== 128'd0) begin
      failures++;
      $display("FAIL core_inst_rd1 got=%h be=%h we=%0b exp=%h be=ffff we=0", c_inst[0], is_be[0], is_we[0], w);
    end
    wait_count(0, 32'd1, 40);
    checks++;
    if (sptr[0] !== 8'd1 || dmem[0][0] !== 8'h07 || vmem[0][0] !== 8'h00) begin
      failures++;
      $display("FAIL single_retire ptr=%0d done=%h flag=%h exp ptr=1 done=07 flag=00", sptr[0], dmem[0][0], vmem[0][0]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad = 0;
    int base = hs_count[0];
    logic [127:0] w = {4{32'hDEAD_0001}};
    imem[0][1] = w;
    inst_q.push_back('{0, w});
    done_q.push_back('{0, 9'd1, 8'h23});
    dly[0] = 3;
    stat_cfg[0] = 7'h11;
    core_ready[0] = 1'b0;
    spur_en[0] = 1'b1;
    host_set(0, 2'd1, 8'h01);
    wait_valid(0, 20, n);
    for (int i = 0; i < 10; i++) begin
      if (c_vld[0] !== 1'b1 || c_inst[0] !== w) bad++;
      step();
    end
    checks++;
    if (bad != 0 || c_vld[0] !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_hold unstable_cycles=%0d vld=%0b exp 0 and 1", bad, c_vld[0]);
    end
    core_ready[0] = 1'b1;
    wait_count(0, 32'd2, 40);
    spur_en[0] = 1'b0;
    checks++;
    if (hs_count[0] - base != 1) begin
      failures++;
      $display("FAIL handshake_count got=%0d exp=1", hs_count[0] - base);
    end
  endtask

  task automatic test_empty_poll();
    int n = 0;
    int bad = 0;
    logic [127:0] w = {2{64'h0123_4567_89AB_CDEF}};
    host_set(0, 2'd2, 8'hFE);
    for (int i = 0; i < 20; i++) begin
      if (is_cs[0] || dn_we[0] || iv_we[0] || c_vld[0]) bad++;
      step();
    end
    checks++;
    if (bad != 0 || sptr[0] !== 8'd2 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL empty_poll bad_cycles=%0d ptr=%0d busy=%0b exp 0, 2, 1", bad, sptr[0], busy[0]);
    end
    imem[0][2] = w;
    inst_q.push_back('{0, w});
    done_q.push_back('{0, 9'd2, 8'hFF});
    dly[0] = 2;
    stat_cfg[0] = 7'h7F;
    host_set(0, 2'd2, 8'h01);
    while (!is_cs[0] && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n < 2 || n > 3) begin
      failures++;
      $display("FAIL fetch_after_set got=%0d cycles exp 2..3", n);
    end
    wait_count(0, 32'd3, 40);
  endtask

  task automatic test_wrap();
    logic [127:0] w3 = {16{8'h33}};
    logic [127:0] w0 = {16{8'hC0}};
    imem[0][3] = w3;
    imem[0][0] = w0;
    inst_q.push_back('{0, w3});
    inst_q.push_back('{0, w0});
    done_q.push_back('{0, 9'd3, 8'h0B});
    done_q.push_back('{0, 9'd0, 8'h0B});
    dly[0] = 4;
    stat_cfg[0] = 7'h05;
    host_set(0, 2'd3, 8'h01);
    host_set(0, 2'd0, 8'h01);
    wait_count(0, 32'd5, 100);
    checks++;
    if (sptr[0] !== 8'd1 || dmem[0][3] !== 8'h0B || dmem[0][0] !== 8'h0B || vmem[0][0] !== 8'h00) begin
      failures++;
      $display("FAIL wrap ptr=%0d done3=%h done0=%h flag0=%h exp 1, 0b, 0b, 00", sptr[0], dmem[0][3], dmem[0][0], vmem[0][0]);
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    int base = hs_count[0];
    logic [127:0] w = {4{32'h5EED_F00D}};
    imem[0][1] = w;
    inst_q.push_back('{0, w});
    done_q.push_back('{0, 9'd1, 8'h45});
    dly[0] = 8;
    stat_cfg[0] = 7'h22;
    host_set(0, 2'd1, 8'h01);
    while (hs_count[0] == base && n < 30) begin
      step();
      n++;
    end
    enable[0] = 1'b0;
    wait_count(0, 32'd6, 40);
    step();
    step();
    checks++;
    if (busy[0] !== 1'b0 || sptr[0] !== 8'd2 || iv_cs[0] !== 1'b0 || vmem[0][1] !== 8'h00) begin
      failures++;
      $display("FAIL enable_drop busy=%0b ptr=%0d iv_cs=%0b flag=%h exp 0, 2, 0, 00", busy[0], sptr[0], iv_cs[0], vmem[0][1]);
    end
  endtask

  task automatic test_reset_exec();
    int n = 0;
    int base = hs_count[0];
    logic [127:0] w = {8{16'hBEEF}};
    imem[0][2] = w;
    inst_q.push_back('{0, w});
    dly[0] = 0;
    host_set(0, 2'd2, 8'h01);
    enable[0] = 1'b1;
    while (hs_count[0] == base && n < 30) begin
      step();
      n++;
    end
    step();
    step();
    checks++;
    if (busy[0] !== 1'b1 || c_vld[0] !== 1'b0) begin
      failures++;
      $display("FAIL exec_parked busy=%0b vld=%0b exp 1 0", busy[0], c_vld[0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || sptr[0] !== 8'd0 || icnt[0] !== 32'd0 || c_inst[0] !== 128'd0 ||
        {iv_cs[0], iv_we[0], is_cs[0], dn_cs[0], dn_we[0]} !== 5'd0) begin
      failures++;
      $display("FAIL async_reset busy=%0b ptr=%0d cnt=%0d inst=%h strobes=%b exp all zero",
               busy[0], sptr[0], icnt[0], c_inst[0], {iv_cs[0], iv_we[0], is_cs[0], dn_cs[0], dn_we[0]});
    end
    enable[0] = 1'b0;
    step();
    step();
    checks++;
    if (vmem[0][2] !== 8'h01 || dmem[0][2] !== 8'hFF) begin
      failures++;
      $display("FAIL reset_slot_untouched flag=%h done=%h exp 01 ff", vmem[0][2], dmem[0][2]);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_rdlat2();
    int n;
    logic [127:0] w = {8{16'hA55A}};
    imem[1][0] = w;
    inst_q.push_back('{1, w});
    done_q.push_back('{1, 9'd0, 8'h07});
    dly[1] = 5;
    stat_cfg[1] = 7'h03;
    core_ready[1] = 1'b1;
    host_set(1, 2'd0, 8'h01);
    enable[1] = 1'b1;
    wait_valid(1, 20, n);
    checks++;
    if (n != 7) begin
      failures++;
      $display("FAIL issue_latency_rd2 got=%0d exp=7", n);
    end
    checks++;
    if (c_inst[1] !== w) begin
      failures++;
      $display("FAIL core_inst_rd2 got=%h exp=%h", c_inst[1], w);
    end
    wait_count(1, 32'd1, 40);
    checks++;
    if (sptr[1] !== 8'd1 || dmem[1][0] !== 8'h07 || vmem[1][0] !== 8'h00) begin
      failures++;
      $display("FAIL rd2_retire ptr=%0d done=%h flag=%h exp 1 07 00", sptr[1], dmem[1][0], vmem[1][0]);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      enable[g] = 1'b0;
      core_ready[g] = 1'b0;
      core_done[g] = 1'b0;
      core_status[g] = 7'h00;
      hw_vld[g] = 1'b0;
      hw_slot[g] = 2'd0;
      hw_val[g] = 8'h00;
      done_cnt[g] = 0;
      dly[g] = 0;
      hs_cyc[g] = 0;
      hs_count[g] = 0;
      stat_cfg[g] = 7'h00;
      spur_en[g] = 1'b0;
      clr_pending[g] = 1'b0;
      last_done_addr[g] = 9'd0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_empty_poll();
    test_wrap();
    test_enable_drop();
    test_reset_exec();
    test_rdlat2();
    checks++;
    if (inst_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain inst_left=%0d done_left=%0d exp 0 0", inst_q.size(), done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
